// File: rtl/multu_hilo.sv
// Sequential unsigned shift-add multiplier with HI/LO result registers.
// Latency: 32 clocks (WIDTH) from the accepted MULTU edge to the HI/LO write, plus one DONE cycle.
// Backpressure: none; start is only sampled in IDLE and is dropped while a multiply is in flight.
//
// Ports:
//   clk      - system clock, all state changes on the rising edge
//   rst      - synchronous active-low reset (aborts any multiply in flight)
//   start    - request strobe, honoured only in IDLE together with Signal == MULTU
//   Signal   - 6-bit funct code shared with the ALU slices
//   dataA    - multiplicand, latched on the accepted start edge
//   dataB    - multiplier, latched on the accepted start edge
//   dataOut  - HI (MFHI), LO (MFLO) or zero, combinational from the result registers
//   busy     - high while the multiply iterates
//   done     - one-cycle pulse on the cycle after HI/LO are written
module multu_hilo #(
    parameter int unsigned WIDTH = 32,
    parameter logic [5:0]  MULTU = 6'b011001,
    parameter logic [5:0]  MFHI  = 6'b010000,
    parameter logic [5:0]  MFLO  = 6'b010010
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       Signal,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic [WIDTH-1:0] dataOut,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam int unsigned PW = 2 * WIDTH + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [PW-1:0]      prod_q,  prod_d;
    logic [CW-1:0]      count_q, count_d;
    logic [WIDTH-1:0]   hi_q,    hi_d;
    logic [WIDTH-1:0]   lo_q,    lo_d;

    // One shift-add step. The upper half is WIDTH+1 bits wide so the
    // carry out of the add lands in the guard bit and is shifted down
    // rather than lost.
    logic [WIDTH:0]     upper_sum;
    logic [PW-1:0]      prod_step;

    always_comb begin
        upper_sum = prod_q[PW-1:WIDTH];
        if (prod_q[0]) begin
            upper_sum = prod_q[PW-1:WIDTH] + {1'b0, mcand_q};
        end
        prod_step = {1'b0, upper_sum, prod_q[WIDTH-1:1]};
    end

    // Next-state and register update logic.
    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;
        count_d = count_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start && (Signal == MULTU)) begin
                    mcand_d = dataA;
                    prod_d  = {1'b0, {WIDTH{1'b0}}, dataB};
                    count_d = '0;
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                prod_d  = prod_step;
                count_d = count_q + 1'b1;
                // Last iteration: commit both halves at once so readers
                // never observe a half-updated HI/LO pair.
                if (count_q == CW'(WIDTH - 1)) begin
                    hi_d    = prod_step[2*WIDTH-1:WIDTH];
                    lo_d    = prod_step[WIDTH-1:0];
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            mcand_q <= '0;
            prod_q  <= '0;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            count_q <= count_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);

    // Read-back mux feeding the shared result bus beside the ALU sum.
    always_comb begin
        dataOut = '0;
        if (Signal == MFHI) begin
            dataOut = hi_q;
        end else if (Signal == MFLO) begin
            dataOut = lo_q;
        end
    end

endmodule

// File: tb/tb_multu_hilo.sv
module tb_multu_hilo;

    localparam int         W      = 32;
    localparam logic [5:0] F_MULT = 6'b011001;
    localparam logic [5:0] F_MFHI = 6'b010000;
    localparam logic [5:0] F_MFLO = 6'b010010;
    localparam logic [5:0] F_ADD  = 6'b100000;

    logic          clk;
    logic          rst;
    logic          start;
    logic [5:0]    Signal;
    logic [W-1:0]  dataA;
    logic [W-1:0]  dataB;
    logic [W-1:0]  dataOut;
    logic          busy;
    logic          done;

    multu_hilo dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .Signal  (Signal),
        .dataA   (dataA),
        .dataB   (dataB),
        .dataOut (dataOut),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [2*W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: on every done pulse pop the expected {HI,LO} and compare the
    // half currently selected by Signal; also check the busy run length.
    int busy_len = 0;
    always @(negedge clk) begin
        if (busy) begin
            busy_len++;
        end else if (done) begin
            logic [2*W-1:0] e;
            done_cnt++;
            chk("busy_len", W'(busy_len), W'(32));
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pulse");
            end else begin
                e = exp_q.pop_front();
                if (Signal == F_MFHI)
                    chk("done_hi", dataOut, e[2*W-1:W]);
                else if (Signal == F_MFLO)
                    chk("done_lo", dataOut, e[W-1:0]);
                else
                    chk("done_zero", dataOut, '0);
            end
            busy_len = 0;
        end else begin
            busy_len = 0;
        end
    end

    // Issue a MULTU at the next edge (E0); returns just after E0.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [5:0] sig_after, input bit expect_result,
                         input logic [2*W-1:0] prod);
        @(posedge clk); #1;
        start  = 1'b1;
        Signal = F_MULT;
        dataA  = a;
        dataB  = b;
        if (expect_result) exp_q.push_back(prod);
        @(posedge clk); #1;
        start  = 1'b0;
        Signal = sig_after;
        dataA  = 32'hDEAD_BEEF;
        dataB  = 32'hCAFE_F00D;
    endtask

    // Wait for done with a cycle budget; optionally check dataOut while busy.
    task automatic wait_done(input bit chk_run, input logic [W-1:0] run_val);
        bit seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
            if (chk_run && busy) chk("run_hold", dataOut, run_val);
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within 40 cycles");
        end
        @(posedge clk); #1;
    endtask

    task automatic check_hilo(input string tag, input logic [W-1:0] hi, input logic [W-1:0] lo);
        Signal = F_MFHI; #1;
        chk({tag, "_hi"}, dataOut, hi);
        Signal = F_MFLO; #1;
        chk({tag, "_lo"}, dataOut, lo);
        Signal = F_ADD;  #1;
        chk({tag, "_other"}, dataOut, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        rst = 1'b0; start = 1'b0; Signal = F_MFHI; dataA = '0; dataB = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_busy", W'(busy), '0);
        chk("rst_done", W'(done), '0);
        chk("rst_mfhi", dataOut, '0);
        Signal = F_MFLO; #1;
        chk("rst_mflo", dataOut, '0);

        // 3 * 5 = 15
        issue(32'd3, 32'd5, F_MFLO, 1, 64'd15);
        wait_done(0, '0);
        check_hilo("m3x5", 32'h0, 32'h0000_000F);

        // 2 * 3 with a second MULTU (7*7) attempted at E5: must be ignored
        issue(32'd2, 32'd3, F_MFLO, 1, 64'd6);
        repeat (4) @(posedge clk);
        #1 start = 1'b1; Signal = F_MULT; dataA = 32'd7; dataB = 32'd7;
        @(posedge clk);
        #1 start = 1'b0; Signal = F_MFLO;
        dc = done_cnt;
        wait_done(0, '0);
        repeat (3) @(posedge clk);
        #1 chk("ignore_once", W'(done_cnt - dc), W'(1));
        check_hilo("m2x3", 32'h0, 32'h0000_0006);

        // Load HI = 0x12345678: 0x2468ACF0 * 2^31
        issue(32'h2468_ACF0, 32'h8000_0000, F_MFHI, 1, 64'h1234_5678_0000_0000);
        wait_done(0, '0);
        check_hilo("load", 32'h1234_5678, 32'h0);

        // Max operands, MFHI held during RUN must show the old HI
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, F_MFHI, 1, 64'hFFFF_FFFE_0000_0001);
        wait_done(1, 32'h1234_5678);
        check_hilo("max", 32'hFFFF_FFFE, 32'h0000_0001);

        // Abort with reset at E10: no done, HI/LO cleared
        dc = done_cnt;
        issue(32'd9, 32'd9, F_MFHI, 0, '0);
        repeat (9) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", W'(busy), '0);
        chk("abort_done", W'(done), '0);
        check_hilo("abort", 32'h0, 32'h0);
        repeat (40) @(posedge clk);
        #1 chk("abort_nodone", W'(done_cnt - dc), '0);

        // Fresh 4 * 4 = 16
        issue(32'd4, 32'd4, F_MFLO, 1, 64'd16);
        wait_done(0, '0);
        check_hilo("m4x4", 32'h0, 32'h0000_0010);

        repeat (2) @(posedge clk);
        chk("done_total", W'(done_cnt), W'(5));
        chk("queue_empty", W'(exp_q.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
